// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags
// Single-clock elastic FIFO. It has exact occupancy, registered full, empty,
// almost-full and almost-empty flags, a synchronous flush, sticky
// overflow/underflow flags and a selectable read mode.
//
// Ports:
//   clk          - single clock; all logic runs on the rising edge
//   rst_n        - synchronous, active-low reset
//   wdata        - write data (DSIZE bits)
//   winc         - write request
//   rinc         - read request
//   flush        - synchronous discard of all contents; takes priority over winc/rinc
//   clr_err      - clears overflow/underflow; a set in the same cycle wins
//   rdata        - read data (DSIZE bits)
//   rvalid       - rdata holds a valid word
//   wfull        - count == DEPTH
//   rempty       - count == 0
//   almost_full  - count >= AF_LEVEL
//   almost_empty - count <= AE_LEVEL
//   count        - current occupancy, 0..DEPTH (ASIZE+1 bits)
//   overflow     - sticky: a write was attempted while full
//   underflow    - sticky: a read was attempted while empty
module fifo_sync_flags #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             flush,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_THR  = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_THR  = (ASIZE+1)'(AE_LEVEL);
  localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE:0] PTR_ZERO = {(ASIZE+1){1'b0}};

  logic [DSIZE-1:0] mem_r [DEPTH];
  logic [ASIZE:0]   wptr_r;
  logic [ASIZE:0]   rptr_r;
  logic [ASIZE:0]   count_r;
  logic             wfull_r;
  logic             rempty_r;
  logic             almost_full_r;
  logic             almost_empty_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             we_s;
  logic             re_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic [ASIZE:0]   count_next_s;

  // Accept decisions, error-set conditions and next occupancy
  always_comb begin
    we_s         = winc & ~wfull_r & ~flush;
    re_s         = rinc & ~rempty_r & ~flush;
    ovf_set_s    = winc & wfull_r & ~flush;
    unf_set_s    = rinc & rempty_r & ~flush;
    count_next_s = count_r;
    if (flush) begin
      count_next_s = PTR_ZERO;
    end else begin
      count_next_s = count_r + (ASIZE+1)'(we_s) - (ASIZE+1)'(re_s);
    end
  end

  // Pointers, occupancy, and flags taken from next count, so they never lag count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_r         <= PTR_ZERO;
      rptr_r         <= PTR_ZERO;
      count_r        <= PTR_ZERO;
      wfull_r        <= 1'b0;
      rempty_r       <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else begin
      if (flush) begin
        wptr_r <= PTR_ZERO;
        rptr_r <= PTR_ZERO;
      end else begin
        if (we_s) wptr_r <= wptr_r + PTR_ONE;
        if (re_s) rptr_r <= rptr_r + PTR_ONE;
      end
      count_r        <= count_next_s;
      wfull_r        <= (count_next_s == DEPTH_C);
      rempty_r       <= (count_next_s == PTR_ZERO);
      almost_full_r  <= (count_next_s >= AF_THR);
      almost_empty_r <= (count_next_s <= AE_THR);
      // A set in the same cycle as clr_err wins over the clear
      overflow_r     <= ovf_set_s | (overflow_r & ~clr_err);
      underflow_r    <= unf_set_s | (underflow_r & ~clr_err);
    end
  end

  // Storage write; the array is deliberately not reset
  always_ff @(posedge clk) begin
    if (rst_n && we_s) begin
      mem_r[wptr_r[ASIZE-1:0]] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // The head word is shown combinationally; rdata is meaningless while empty
      assign rdata  = mem_r[rptr_r[ASIZE-1:0]];
      assign rvalid = ~rempty_r;
    end else begin : g_reg
      logic [DSIZE-1:0] rdata_r;
      logic             rvalid_r;

      // Registered read. rdata holds until the next accepted read, and rvalid pulses for one cycle
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata_r  <= {DSIZE{1'b0}};
          rvalid_r <= 1'b0;
        end else begin
          if (re_s) rdata_r <= mem_r[rptr_r[ASIZE-1:0]];
          rvalid_r <= re_s;
        end
      end

      assign rdata  = rdata_r;
      assign rvalid = rvalid_r;
    end
  endgenerate

  assign count        = count_r;
  assign wfull        = wfull_r;
  assign rempty       = rempty_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
